// File: rtl/inst_stream_encoder_pkg.sv
// Shared MIPS encoding constants and the symbolic op enumeration used by the
// program loader (inst_stream_encoder) and its field packer.
package inst_stream_encoder_pkg;

    localparam logic [5:0] OPCODE_RTYPE = 6'b000000;
    localparam logic [5:0] OPCODE_ADDI  = 6'b001000;
    localparam logic [5:0] OPCODE_ORI   = 6'b001101;
    localparam logic [5:0] OPCODE_LW    = 6'b100011;
    localparam logic [5:0] OPCODE_SW    = 6'b101011;
    localparam logic [5:0] OPCODE_BEQ   = 6'b000100;
    localparam logic [5:0] OPCODE_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU = 6'b101011;

    typedef enum logic [3:0] {
        SOP_NOP     = 4'd0,
        SOP_ADD     = 4'd1,
        SOP_ADDU    = 4'd2,
        SOP_SUB     = 4'd3,
        SOP_SUBU    = 4'd4,
        SOP_AND     = 4'd5,
        SOP_OR      = 4'd6,
        SOP_SLT     = 4'd7,
        SOP_SLTU    = 4'd8,
        SOP_ADDI    = 4'd9,
        SOP_ORI     = 4'd10,
        SOP_LW      = 4'd11,
        SOP_SW      = 4'd12,
        SOP_BEQ     = 4'd13,
        SOP_J       = 4'd14,
        SOP_ILLEGAL = 4'd15
    } sop_e;

    function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] funct);
        return {OPCODE_RTYPE, rs, rt, rd, 5'b00000, funct};
    endfunction

    function automatic logic [31:0] pack_i(input logic [5:0] opcode, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm16);
        return {opcode, rs, rt, imm16};
    endfunction

endpackage

// File: rtl/inst_field_packer.sv
// Combinational encoder: symbolic op plus register/immediate fields to a
// 32-bit MIPS instruction word, flagging the reserved op code as illegal.
module inst_field_packer
    import inst_stream_encoder_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [25:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (sop_e'(op))
            SOP_NOP:  word = '0;
            SOP_ADD:  word = pack_r(rs, rt, rd, FUNCT_ADD);
            SOP_ADDU: word = pack_r(rs, rt, rd, FUNCT_ADDU);
            SOP_SUB:  word = pack_r(rs, rt, rd, FUNCT_SUB);
            SOP_SUBU: word = pack_r(rs, rt, rd, FUNCT_SUBU);
            SOP_AND:  word = pack_r(rs, rt, rd, FUNCT_AND);
            SOP_OR:   word = pack_r(rs, rt, rd, FUNCT_OR);
            SOP_SLT:  word = pack_r(rs, rt, rd, FUNCT_SLT);
            SOP_SLTU: word = pack_r(rs, rt, rd, FUNCT_SLTU);
            SOP_ADDI: word = pack_i(OPCODE_ADDI, rs, rt, imm[15:0]);
            SOP_ORI:  word = pack_i(OPCODE_ORI, rs, rt, imm[15:0]);
            SOP_LW:   word = pack_i(OPCODE_LW, rs, rt, imm[15:0]);
            SOP_SW:   word = pack_i(OPCODE_SW, rs, rt, imm[15:0]);
            SOP_BEQ:  word = pack_i(OPCODE_BEQ, rs, rt, imm[15:0]);
            SOP_J:    word = {OPCODE_J, imm};
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/inst_stream_encoder.sv
// Program loader: encodes a valid/ready stream of symbolic MIPS ops into
// consecutive instruction-memory words while holding the CPU.
// Optional build macro INST_STREAM_ENCODER_CKSUM_EN adds an XOR checksum port.
module inst_stream_encoder
    import inst_stream_encoder_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [25:0]       in_imm,
    input  logic              in_last,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
`ifdef INST_STREAM_ENCODER_CKSUM_EN
    ,
    output logic [31:0]       cksum
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [ADDR_W-1:0] PTR_MAX = '1;

    logic [1:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [31:0]       enc_word;
    logic              enc_illegal;

    inst_field_packer u_packer (
        .op      (in_op),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .imm     (in_imm),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    assign in_ready = (state == ST_LOAD);
    assign cpu_hold = (state == ST_LOAD);
    assign done     = (state == ST_DONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            count    <= '0;
            err      <= 1'b0;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= '0;
`ifdef INST_STREAM_ENCODER_CKSUM_EN
            cksum    <= '0;
`endif
        end else begin
            im_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_LOAD;
                        ptr   <= '0;
                        count <= '0;
                        err   <= 1'b0;
`ifdef INST_STREAM_ENCODER_CKSUM_EN
                        cksum <= '0;
`endif
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        if (enc_illegal) begin
                            err <= 1'b1;
                        end else begin
                            im_we    <= 1'b1;
                            im_addr  <= ptr;
                            im_wdata <= enc_word;
                            ptr      <= ptr + 1'b1;
                            count    <= count + 1'b1;
`ifdef INST_STREAM_ENCODER_CKSUM_EN
                            cksum    <= cksum ^ enc_word;
`endif
                        end
                        // Filling the last address without in_last ends the session as an overflow.
                        if (in_last) begin
                            state <= ST_DONE;
                        end else if (!enc_illegal && ptr == PTR_MAX) begin
                            state <= ST_DONE;
                            err   <= 1'b1;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_stream_encoder.sv
// Scoreboard bench for inst_stream_encoder: an ADDR_W=8 instance plus an
// ADDR_W=2 instance for the overflow case; expected writes are queued at accept.
`timescale 1ns/1ps
module tb_inst_stream_encoder;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start, start2;
    logic        in_valid;
    logic [3:0]  in_op;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [25:0] in_imm;
    logic        in_last;

    logic        in_ready, im_we, cpu_hold, done, err;
    logic [7:0]  im_addr;
    logic [31:0] im_wdata;
    logic [8:0]  count;

    logic        in_ready2, im_we2, cpu_hold2, done2, err2;
    logic [1:0]  im_addr2;
    logic [31:0] im_wdata2;
    logic [2:0]  count2;
`ifdef INST_STREAM_ENCODER_CKSUM_EN
    logic [31:0] cksum, cksum2;
`endif

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [39:0] q[$];
    logic [39:0] q2[$];
    logic [7:0]  exp_ptr;
    logic        sel;

    logic        m_ready, m_done, m_hold, m_err;
    logic [8:0]  m_count;
    assign m_ready = sel ? in_ready2 : in_ready;
    assign m_done  = sel ? done2     : done;
    assign m_hold  = sel ? cpu_hold2 : cpu_hold;
    assign m_err   = sel ? err2      : err;
    assign m_count = sel ? {6'b0, count2} : count;

    always #5 clk = ~clk;

    inst_stream_encoder #(.ADDR_W(8)) u_dut (
        .clk(clk), .rstn(rstn), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_last(in_last), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .cpu_hold(cpu_hold), .done(done), .err(err), .count(count)
`ifdef INST_STREAM_ENCODER_CKSUM_EN
        , .cksum(cksum)
`endif
    );

    inst_stream_encoder #(.ADDR_W(2)) u_dut2 (
        .clk(clk), .rstn(rstn), .start(start2), .in_valid(in_valid), .in_ready(in_ready2),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_last(in_last), .im_we(im_we2), .im_addr(im_addr2), .im_wdata(im_wdata2),
        .cpu_hold(cpu_hold2), .done(done2), .err(err2), .count(count2)
`ifdef INST_STREAM_ENCODER_CKSUM_EN
        , .cksum(cksum2)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Write monitors: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            if (q.size() == 0) check("unexpected_write", {im_addr, im_wdata}, 64'h0);
            else check("write", {24'h0, im_addr, im_wdata}, {24'h0, q.pop_front()});
        end
        if (im_we2 === 1'b1) begin
            if (q2.size() == 0) check("unexpected_write2", {im_addr2, im_wdata2}, 64'h0);
            else check("write2", {30'h0, im_addr2, im_wdata2}, {24'h0, q2.pop_front()});
        end
    end

    task automatic do_start();
        if (sel) start2 = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start2 = 1'b0;
        exp_ptr = '0;
        check("hold_on", {63'h0, m_hold}, 64'h1);
    endtask

    task automatic send_op(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [25:0] imm, input logic last,
                           input logic [31:0] exp_word, input int unsigned gap);
        int unsigned n;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_last = last;
        in_valid = 1'b1;
        n = 0;
        while (!m_ready && n < 40) begin @(posedge clk); #1; n++; end
        if (!m_ready) begin
            check("accept_timeout", 64'h0, 64'h1);
            in_valid = 1'b0; in_last = 1'b0;
            return;
        end
        if (op != 4'd15) begin
            if (sel) q2.push_back({exp_ptr, exp_word});
            else q.push_back({exp_ptr, exp_word});
            exp_ptr = exp_ptr + 8'd1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_done(input logic [8:0] exp_count, input logic exp_err);
        int unsigned n;
        n = 0;
        while (!m_done && n < 20) begin @(posedge clk); #1; n++; end
        check("done_seen", {63'h0, m_done}, 64'h1);
        check("count", {55'h0, m_count}, {55'h0, exp_count});
        check("err", {63'h0, m_err}, {63'h0, exp_err});
        check("hold_off", {63'h0, m_hold}, 64'h0);
        @(posedge clk); #1;
        check("done_pulse", {63'h0, m_done}, 64'h0);
        check("q_empty", sel ? 64'(q2.size()) : 64'(q.size()), 64'h0);
    endtask

    task automatic idle_valid(input string tag);
        in_valid = 1'b1; in_op = 4'd1; in_last = 1'b0;
        repeat (3) begin
            check(tag, {63'h0, m_ready}, 64'h0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic check_reset_outs();
        check("rst_outs", {in_ready, im_we, cpu_hold, done, err, im_addr, im_wdata, count}, 64'h0);
        check("rst_outs2", {in_ready2, im_we2, cpu_hold2, done2, err2, im_addr2, im_wdata2, count2}, 64'h0);
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; start2 = 1'b0; in_valid = 1'b0; in_op = '0;
        in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_last = 1'b0;
        sel = 1'b0; exp_ptr = '0;
        repeat (3) @(posedge clk);
        #1 check_reset_outs();
        rstn = 1'b1;
        @(posedge clk); #1;

        idle_valid("idle_ready");

        do_start();
        send_op(4'd1, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0, 32'h0022_1820, 0);
        send_op(4'd10, 5'd0, 5'd4, 5'd0, 26'h00FF, 1'b1, 32'h3404_00FF, 0);
        wait_done(9'd2, 1'b0);

        do_start();
        send_op(4'd14, 5'd0, 5'd0, 5'd0, 26'h000_0010, 1'b0, 32'h0800_0010, 0);
        send_op(4'd11, 5'd29, 5'd8, 5'd0, 26'h4, 1'b0, 32'h8FA8_0004, 0);
        send_op(4'd12, 5'd29, 5'd8, 5'd0, 26'h8, 1'b0, 32'hAFA8_0008, 1);
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        send_op(4'd8, 5'd4, 5'd5, 5'd6, 26'd0, 1'b0, 32'h0085_302B, 0);
        send_op(4'd9, 5'd2, 5'd3, 5'd0, 26'h8000, 1'b0, 32'h2043_8000, 0);
        send_op(4'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0, 32'h0000_0000, 0);
        send_op(4'd13, 5'd1, 5'd2, 5'd0, 26'hFFFF, 1'b1, 32'h1022_FFFF, 0);
        wait_done(9'd7, 1'b0);

        do_start();
        send_op(4'd1, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0, 32'h0022_1820, 0);
        send_op(4'd15, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0, 32'h0, 0);
        send_op(4'd1, 5'd7, 5'd8, 5'd9, 26'd0, 1'b1, 32'h00E8_4820, 0);
        wait_done(9'd2, 1'b1);

        do_start();
        send_op(4'd15, 5'd0, 5'd0, 5'd0, 26'd0, 1'b1, 32'h0, 0);
        wait_done(9'd0, 1'b1);

        sel = 1'b1;
        do_start();
        send_op(4'd6, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0, 32'h0022_1825, 0);
        send_op(4'd5, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0, 32'h0022_1824, 0);
        send_op(4'd4, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0, 32'h0022_1823, 0);
        send_op(4'd2, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0, 32'h0022_1821, 0);
        wait_done(9'd4, 1'b1);
        idle_valid("overflow_5th");
        sel = 1'b0;

        do_start();
        send_op(4'd1, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0, 32'h0022_1820, $urandom_range(0, 3));
        send_op(4'd3, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0, 32'h0022_1822, $urandom_range(0, 3));
        send_op(4'd6, 5'd1, 5'd2, 5'd3, 26'd0, 1'b1, 32'h0022_1825, $urandom_range(0, 3));
        wait_done(9'd3, 1'b0);

        do_start();
        send_op(4'd1, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0, 32'h0022_1820, 0);
        in_valid = 1'b1; in_op = 4'd1;
        #3 rstn = 1'b0;
        #1 check_reset_outs();
        in_valid = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        q.delete();
        do_start();
        send_op(4'd1, 5'd1, 5'd2, 5'd3, 26'd0, 1'b1, 32'h0022_1820, 0);
        wait_done(9'd1, 1'b0);

`ifdef INST_STREAM_ENCODER_CKSUM_EN
        do_start();
        send_op(4'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0, 32'h0000_0000, 0);
        send_op(4'd14, 5'd0, 5'd0, 5'd0, 26'd1, 1'b1, 32'h0800_0001, 0);
        while (!done) begin @(posedge clk); #1; end
        check("cksum", {32'h0, cksum}, 64'h0800_0001);
        @(posedge clk); #1;
`endif

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
